spi_slave: RTL
==============

# spi_slave

APB-programmable SPI target: the responder end of the team's SPI master link. It oversamples the SPI pins in the `pclk_i` domain and captures one instruction byte plus up to five data bytes per chip-select frame into readable registers. During each byte slot it shifts out a pre-loaded transmit byte on MISO. Software loads TX bytes, enables the block, and reads RX bytes and status after the frame ends.

## Interface
Parameters:
- `NUM_DATA`, default 5: data-byte slots after the instruction byte. Address map below assumes 5.

Ports:
- `pclk_i`  in  1  APB clock; also the oversampling clock.
- `presetn_i`  in  1  reset; asynchronous, active-low.
- `paddr_i`  in  8  APB address.
- `psel_i`, `penable_i`, `pwrite_i`  in  1  APB controls.
- `pwdata_i`  in  8  APB write data.
- `prdata_o`  out  8  APB read data.
- `pready_o`  out  1  tied 1; zero wait states.
- `pslverr_o`  out  1  error response on the access phase.
- `sclk_i`  in  1  SPI clock; idles high.
- `cs_n_i`  in  1  chip select, active-low.
- `mosi_i`  in  1  SPI data from the master.
- `miso_o`  out  1  SPI data to the master.
- `miso_oe_o`  out  1  MISO output enable.
- `irq_o`  out  1  frame-done interrupt, level.

## Operation
- SPI mode: CPOL=1, CPHA=1, MSB first. Slave shifts on the `sclk` falling edge; samples MOSI on the rising edge.
- Register map (8-bit):
  - 0x00 CTRL, RW: bit0 EN, bit1 IRQ_EN, bit2 CLR (write-1 self-clearing; clears STATUS[3:1] and COUNT).
  - 0x01–0x06 TX0–TX5, RW: TX0 is sent during the instruction slot; TXk during data slot k.
  - 0x08 STATUS, RO: bit0 BUSY, bit1 DONE, bit2 OVERRUN, bit3 PARTIAL, bits[6:4] COUNT (complete bytes in the last frame, saturating at 7).
  - 0x10 RX_INSTR, RO. 0x11–0x15 RX1–RX5, RO.
- `pslverr_o` = 1 on any of:
  - an unmapped address;
  - a write to an RO register;
  - a write to TX0–TX5 while BUSY. The write is dropped.
- States:
  - IDLE: EN=1 and synced cs falls → ACTIVE. BUSY=1, COUNT=0, DONE/PARTIAL/OVERRUN cleared. TX0 loaded into the tx shift register; bit counter = 0, slot = 0.
  - ACTIVE: on each sclk rising edge, shift MOSI into the rx shift register and increment the bit counter. On the 8th rising edge:
    - slot 0 stores to RX_INSTR; slots 1–5 store to RXk;
    - slot ≥ 6 discards the byte and sets OVERRUN;
    - slot++, COUNT++ (saturating).
  - On each sclk falling edge: if the bit counter is 0, load TX[slot] (all-ones if slot ≥ 6); otherwise shift left.
  - ACTIVE, cs rises → IDLE. BUSY=0, DONE=1. If the bit counter is ≠ 0, set PARTIAL and drop the partial byte.
  - ACTIVE, EN cleared → ABORT. ABORT drops all activity and returns to IDLE on cs rise without setting DONE.
- `miso_o` = tx_shift[7] in ACTIVE, else 1. `miso_oe_o` = 1 only in ACTIVE.
- `irq_o` = DONE & IRQ_EN.
- Reset: all registers 0, state IDLE, `miso_o`=1, `miso_oe_o`=0, `irq_o`=0, `pslverr_o`=0, `prdata_o`=0. Reset mid-frame aborts immediately; the rest of that frame is ignored until cs rises.

## Timing
- `sclk_i`, `cs_n_i`, `mosi_i` each pass through 2-FF synchronizers. Edges are detected against a third flop.
- Pad edge → internal action: 3 `pclk_i` cycles. Pad sclk fall → `miso_o` update: ≤ 4 cycles.
- Constraint: sclk high and low phases ≥ 4 `pclk_i` cycles each (sclk ≤ pclk/8).
- MOSI is sampled from the synchronized copy, so it stays aligned with the synchronized sclk.
- APB write commits on the cycle with `psel_i & penable_i & pwrite_i`.
- `prdata_o` is combinational from `paddr_i` while `psel_i & ~pwrite_i`; otherwise 0.
- Simultaneous APB CLR and frame end: the frame-end update wins, so DONE=1.
- RX register updates are visible to APB reads on the cycle after the byte completes.

## Structure
- Package `spi_pkg` holds:
  - register address localparams;
  - STATUS/CTRL bit positions;
  - state encoding (IDLE/ACTIVE/ABORT);
  - `NUM_DATA` default.
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall pulse outputs. Instantiated for `sclk_i` and `cs_n_i`; `mosi_i` uses its synchronized output only.

## Test plan
- Reset, then read every register → all 0. `miso_oe_o`=0, `miso_o`=1.
- TX0=0xA5, TX1=0x3C, EN=1. Master sends 0x9F, 0x12 → RX_INSTR=0x9F, RX1=0x12. MISO observed as 0xA5, 0x3C. STATUS=0x22 (COUNT=2, DONE).
- Seven-byte frame → RX1–RX5 hold bytes 2–6. OVERRUN=1, COUNT=7. MISO=0xFF during byte 7.
- cs rises after 3 bits of byte 2 → PARTIAL=1, COUNT=1, RX1 unchanged.
- Write TX1 during BUSY → `pslverr_o`=1 and TX1 unchanged. Write 0x08 → `pslverr_o`=1.
- IRQ_EN=1, frame completes → `irq_o`=1. CLR → `irq_o`=0. Assert `presetn_i` mid-byte → state IDLE, `miso_oe_o`=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: register map, bit positions and FSM encoding.
package spi_pkg;

    localparam int NUM_DATA_DEF = 5;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_TX0    = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam logic [7:0] ADDR_RX0    = 8'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_PARTIAL   = 3;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ABORT  = 2'd2
    } state_e;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an SPI pad with single-cycle rise/fall pulses
// taken against a third flop.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic pclk_i,
    input  logic presetn_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus history flop for edge detection
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
        end else begin
            meta_r <= async_i;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_o = sync_r;
    assign rise_o = sync_r & ~prev_r;
    assign fall_o = ~sync_r & prev_r;

endmodule

// File: rtl/spi_slave.sv
// APB-programmable SPI target (CPOL=1, CPHA=1, MSB first) capturing an
// instruction byte plus NUM_DATA data bytes per chip-select frame.
module spi_slave
    import spi_pkg::*;
#(
    parameter int NUM_DATA = NUM_DATA_DEF
) (
    input  logic       pclk_i,
    input  logic       presetn_i,
    input  logic [7:0] paddr_i,
    input  logic       psel_i,
    input  logic       penable_i,
    input  logic       pwrite_i,
    input  logic [7:0] pwdata_i,
    output logic [7:0] prdata_o,
    output logic       pready_o,
    output logic       pslverr_o,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic       irq_o
);

    localparam logic [2:0] LAST_SLOT    = 3'(NUM_DATA);
    localparam logic [7:0] TX_LAST_ADDR = ADDR_TX0 + 8'(NUM_DATA);
    localparam logic [7:0] RX_LAST_ADDR = ADDR_RX0 + 8'(NUM_DATA);

    logic [7:0] tx_r [0:NUM_DATA];
    logic [7:0] rx_r [0:NUM_DATA];
    logic       en_r;
    logic       irq_en_r;
    state_e     state_r;
    logic [7:0] tx_shift_r;
    logic [6:0] rx_shift_r;
    logic [2:0] bit_cnt_r;
    logic [2:0] slot_r;
    logic [2:0] count_r;
    logic       done_r;
    logic       overrun_r;
    logic       partial_r;
    logic       miso_r;
    logic       miso_oe_r;
    logic       irq_r;

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic unused_s;

    logic       busy_s;
    logic       access_s;
    logic       wr_s;
    logic       clr_s;
    logic       is_ctrl_s, is_tx_s, is_status_s, is_rx_s, mapped_s;
    logic [2:0] tx_idx_s;
    logic [2:0] rx_idx_s;
    logic [7:0] status_s;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
        .pclk_i    (pclk_i),
        .presetn_i (presetn_i),
        .async_i   (sclk_i),
        .sync_o    (sclk_lvl_s),
        .rise_o    (sclk_rise_s),
        .fall_o    (sclk_fall_s)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .pclk_i    (pclk_i),
        .presetn_i (presetn_i),
        .async_i   (cs_n_i),
        .sync_o    (cs_lvl_s),
        .rise_o    (cs_rise_s),
        .fall_o    (cs_fall_s)
    );

    // MOSI shares the sclk synchronizer depth so samples line up with sclk edges
    spi_sync_edge #(.RST_VAL(1'b1)) u_mosi_sync (
        .pclk_i    (pclk_i),
        .presetn_i (presetn_i),
        .async_i   (mosi_i),
        .sync_o    (mosi_s),
        .rise_o    (mosi_rise_s),
        .fall_o    (mosi_fall_s)
    );

    assign unused_s = &{1'b0, sclk_lvl_s, mosi_rise_s, mosi_fall_s};

    assign busy_s   = (state_r == S_ACTIVE);
    assign access_s = psel_i & penable_i;
    assign wr_s     = access_s & pwrite_i;
    assign pready_o = 1'b1;
    assign tx_idx_s = paddr_i[2:0] - 3'd1;
    assign rx_idx_s = paddr_i[2:0];
    assign status_s = {1'b0, count_r, partial_r, overrun_r, done_r, busy_s};

    // Address decode
    always_comb begin
        is_ctrl_s   = (paddr_i == ADDR_CTRL);
        is_tx_s     = (paddr_i >= ADDR_TX0) && (paddr_i <= TX_LAST_ADDR);
        is_status_s = (paddr_i == ADDR_STATUS);
        is_rx_s     = (paddr_i >= ADDR_RX0) && (paddr_i <= RX_LAST_ADDR);
        mapped_s    = is_ctrl_s | is_tx_s | is_status_s | is_rx_s;
        clr_s       = wr_s & is_ctrl_s & pwdata_i[CTRL_CLR];
    end

    // Error response: unmapped, RO write, or TX write during a frame
    always_comb begin
        pslverr_o = 1'b0;
        if (access_s) begin
            pslverr_o = ~mapped_s
                      | (pwrite_i & (is_status_s | is_rx_s))
                      | (pwrite_i & is_tx_s & busy_s);
        end else begin
            pslverr_o = 1'b0;
        end
    end

    // Combinational read mux, zero outside a read access
    always_comb begin
        prdata_o = 8'h00;
        if (psel_i && !pwrite_i) begin
            if (is_ctrl_s) begin
                prdata_o = {6'b0, irq_en_r, en_r};
            end else if (is_tx_s) begin
                prdata_o = tx_r[tx_idx_s];
            end else if (is_status_s) begin
                prdata_o = status_s;
            end else if (is_rx_s) begin
                prdata_o = rx_r[rx_idx_s];
            end else begin
                prdata_o = 8'h00;
            end
        end else begin
            prdata_o = 8'h00;
        end
    end

    // APB-writable control and TX registers
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            en_r     <= 1'b0;
            irq_en_r <= 1'b0;
            for (int i = 0; i <= NUM_DATA; i++) begin
                tx_r[i] <= 8'h00;
            end
        end else if (wr_s) begin
            if (is_ctrl_s) begin
                en_r     <= pwdata_i[CTRL_EN];
                irq_en_r <= pwdata_i[CTRL_IRQ_EN];
            end else if (is_tx_s && !busy_s) begin
                tx_r[tx_idx_s] <= pwdata_i;
            end
        end
    end

    // Frame FSM; CLR is applied first so a same-cycle frame event overrides it
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_r    <= S_IDLE;
            tx_shift_r <= 8'h00;
            rx_shift_r <= 7'h00;
            bit_cnt_r  <= 3'd0;
            slot_r     <= 3'd0;
            count_r    <= 3'd0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
            partial_r  <= 1'b0;
            for (int i = 0; i <= NUM_DATA; i++) begin
                rx_r[i] <= 8'h00;
            end
        end else begin
            if (clr_s) begin
                done_r    <= 1'b0;
                overrun_r <= 1'b0;
                partial_r <= 1'b0;
                count_r   <= 3'd0;
            end
            case (state_r)
                S_IDLE: begin
                    if (en_r && cs_fall_s) begin
                        state_r    <= S_ACTIVE;
                        count_r    <= 3'd0;
                        done_r     <= 1'b0;
                        overrun_r  <= 1'b0;
                        partial_r  <= 1'b0;
                        tx_shift_r <= tx_r[0];
                        bit_cnt_r  <= 3'd0;
                        slot_r     <= 3'd0;
                    end
                end
                S_ACTIVE: begin
                    if (cs_rise_s) begin
                        state_r   <= S_IDLE;
                        done_r    <= 1'b1;
                        partial_r <= (bit_cnt_r != 3'd0);
                    end else if (!en_r) begin
                        state_r <= S_ABORT;
                    end else begin
                        if (sclk_rise_s) begin
                            rx_shift_r <= {rx_shift_r[5:0], mosi_s};
                            bit_cnt_r  <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                if (slot_r <= LAST_SLOT) begin
                                    rx_r[slot_r] <= {rx_shift_r, mosi_s};
                                end else begin
                                    overrun_r <= 1'b1;
                                end
                                slot_r  <= sat_inc3(slot_r);
                                count_r <= sat_inc3(count_r);
                            end
                        end
                        if (sclk_fall_s) begin
                            if (bit_cnt_r == 3'd0) begin
                                tx_shift_r <= (slot_r <= LAST_SLOT) ? tx_r[slot_r] : 8'hFF;
                            end else begin
                                tx_shift_r <= {tx_shift_r[6:0], 1'b1};
                            end
                        end
                    end
                end
                S_ABORT: begin
                    if (cs_lvl_s) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Registered pad-facing outputs
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            miso_r    <= 1'b1;
            miso_oe_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            miso_r    <= busy_s ? tx_shift_r[7] : 1'b1;
            miso_oe_r <= busy_s;
            irq_r     <= done_r & irq_en_r;
        end
    end

    assign miso_o    = miso_r;
    assign miso_oe_o = miso_oe_r;
    assign irq_o     = irq_r;

endmodule
